// File: rtl/spi_debug_pkg.sv
// Shared constants and state encoding for the SPI debug write bridge.
package spi_debug_pkg;

    localparam int SPI_WORD = 16;
    localparam logic [SPI_WORD-1:0] ID_WORD_DEFAULT = 16'hA55A;

    // Bit positions of the conditioned pins in the synchronizer array
    localparam int SYNC_MOSI = 0;
    localparam int SYNC_CLK  = 1;
    localparam int SYNC_CS   = 2;
    localparam int NUM_SYNC  = 3;

    typedef enum logic [1:0] {
        WAIT_CS = 2'd0,
        IDLE    = 2'd1,
        ADDR    = 2'd2,
        DATA    = 2'd3
    } state_e;

endpackage

// File: rtl/spi_debug_bridge_sync_edge.sv
// Two-flop synchronizer with a history flop for single-cycle edge pulses.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic hist;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta  <= RST_VAL;
            level <= RST_VAL;
            hist  <= RST_VAL;
        end else begin
            meta  <= din;
            level <= meta;
            hist  <= level;
        end
    end

    assign rise = level & ~hist;
    assign fall = ~level & hist;

endmodule

// File: rtl/spi_debug_bridge.sv
// SPI mode-0 slave that turns an address word plus streamed data words into
// single-cycle memory write strobes, echoing each data word back on MISO.
module spi_debug_bridge
    import spi_debug_pkg::*;
#(
    parameter int                AWIDTH  = 16,
    parameter int                DWIDTH  = SPI_WORD,
    parameter logic [DWIDTH-1:0] ID_WORD = ID_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_mosi,
    input  logic              spi_clk,
    input  logic              spi_cs,
    output logic              spi_miso,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              wr_en,
    output logic              active
);

    localparam int               CW   = $clog2(DWIDTH);
    localparam logic [CW-1:0]    LAST = CW'(DWIDTH - 1);
    localparam logic [NUM_SYNC-1:0] SYNC_RST = NUM_SYNC'(1) << SYNC_CS;

    logic [NUM_SYNC-1:0] pin_raw;
    logic [NUM_SYNC-1:0] pin_lvl;
    logic [NUM_SYNC-1:0] pin_rise;
    logic [NUM_SYNC-1:0] pin_fall;

    assign pin_raw = {spi_cs, spi_clk, spi_mosi};

    for (genvar i = 0; i < NUM_SYNC; i++) begin : g_sync
        sync_edge #(.RST_VAL(SYNC_RST[i])) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (pin_raw[i]),
            .level   (pin_lvl[i]),
            .rise    (pin_rise[i]),
            .fall    (pin_fall[i])
        );
    end

    logic cs_lvl, mosi_lvl, sclk_rise, sclk_fall;
    assign cs_lvl    = pin_lvl[SYNC_CS];
    assign mosi_lvl  = pin_lvl[SYNC_MOSI];
    assign sclk_rise = pin_rise[SYNC_CLK];
    assign sclk_fall = pin_fall[SYNC_CLK];

    logic sync_unused;
    assign sync_unused = ^{pin_rise[SYNC_CS], pin_fall[SYNC_CS],
                           pin_rise[SYNC_MOSI], pin_fall[SYNC_MOSI], pin_lvl[SYNC_CLK]};

    state_e            state;
    logic [1:0]        settle;
    logic [CW-1:0]     bit_cnt;
    logic [DWIDTH-1:0] rx;
    logic [DWIDTH-1:0] tx;
    logic [AWIDTH-1:0] addr_reg;
    logic [DWIDTH-1:0] rx_next;

    assign rx_next = {rx[DWIDTH-2:0], mosi_lvl};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= WAIT_CS;
            settle   <= '0;
            bit_cnt  <= '0;
            rx       <= '0;
            tx       <= '0;
            addr_reg <= '0;
            spi_miso <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            active   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                // Synchronizer flops hold their reset value for a few cycles;
                // let them fill with the real pin before trusting cs high.
                WAIT_CS: begin
                    active <= 1'b0;
                    if (settle != 2'd3)
                        settle <= settle + 2'd1;
                    else if (cs_lvl)
                        state <= IDLE;
                end
                // tx holds the bits still to go; the MSB is driven immediately.
                IDLE: begin
                    active <= 1'b0;
                    if (!cs_lvl) begin
                        state    <= ADDR;
                        active   <= 1'b1;
                        bit_cnt  <= '0;
                        tx       <= {ID_WORD[DWIDTH-2:0], 1'b0};
                        spi_miso <= ID_WORD[DWIDTH-1];
                    end
                end
                ADDR, DATA: begin
                    if (sclk_rise) begin
                        rx <= rx_next;
                        if (bit_cnt == LAST) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                addr_reg <= AWIDTH'(rx_next);
                                state    <= DATA;
                            end else begin
                                wr_addr  <= addr_reg;
                                wr_data  <= rx_next;
                                wr_en    <= 1'b1;
                                addr_reg <= addr_reg + AWIDTH'(1);
                                tx       <= rx_next;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (sclk_fall) begin
                        spi_miso <= tx[DWIDTH-1];
                        tx       <= tx << 1;
                    end
                    // A word finishing in this same cycle still commits above.
                    if (cs_lvl) begin
                        state    <= IDLE;
                        active   <= 1'b0;
                        spi_miso <= 1'b0;
                    end
                end
                default: state <= WAIT_CS;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_debug_bridge.sv
// Bench for spi_debug_bridge: table of frames plus hand-written corner sequences,
// with a write scoreboard fed by the stimulus and drained by a wr_en monitor.
module tb_spi_debug_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_mosi, spi_clk, spi_cs;
    logic        spi_miso;
    logic [15:0] wr_addr, wr_data;
    logic        wr_en, active;

    spi_debug_bridge dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi_mosi (spi_mosi),
        .spi_clk  (spi_clk),
        .spi_cs   (spi_cs),
        .spi_miso (spi_miso),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] addr, d0, d1;       // stimulus
        logic [15:0] ea0, ea1;           // expected write addresses
        logic [15:0] m_a, m_d0, m_d1;    // expected MISO word per SPI word
    } frame_vec_t;

    wr_t        exp_q[$];
    frame_vec_t vecs[3];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_wr_en: got addr=%h data=%h, required no write",
                         wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {16'h0, wr_addr}, {16'h0, e.addr});
                check("wr_data", {16'h0, wr_data}, {16'h0, e.data});
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift the top nbits of w MSB first; MISO sampled just before each rising edge.
    task automatic spi_bits(input logic [15:0] w, input int nbits, output logic [15:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = w[15-i];
            clks(4);
            rd[15-i] = spi_miso;
            spi_clk = 1'b1;
            clks(8);
            spi_clk = 1'b0;
            clks(4);
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        clks(8);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        clks(16);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        int          base;

        vecs[0] = '{16'h0100, 16'hBEEF, 16'hCAFE, 16'h0100, 16'h0101, 16'hA55A, 16'h0000, 16'hBEEF};
        vecs[1] = '{16'hFFFF, 16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 16'hA55A, 16'h0000, 16'h0001};
        vecs[2] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 16'h1235, 16'hA55A, 16'h0000, 16'h0000};

        // Reset with cs already low; that frame must never be honoured
        reset_n  = 1'b0;
        spi_cs   = 1'b0;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        clks(4);
        check("rst_wr_en",   {31'h0, wr_en},    32'h0);
        check("rst_miso",    {31'h0, spi_miso}, 32'h0);
        check("rst_wr_addr", {16'h0, wr_addr},  32'h0);
        check("rst_wr_data", {16'h0, wr_data},  32'h0);
        check("rst_active",  {31'h0, active},   32'h0);
        reset_n = 1'b1;
        clks(8);
        spi_bits(16'h1234, 16, rd);
        spi_bits(16'h5678, 16, rd);
        check("stuck_frame_writes", wr_cnt, 0);
        check("stuck_frame_active", {31'h0, active}, 32'h0);
        cs_high();

        for (int v = 0; v < 3; v++) begin
            cs_low();
            check("frame_active", {31'h0, active}, 32'h1);
            spi_bits(vecs[v].addr, 16, rd);
            check("miso_addr_word", {16'h0, rd}, {16'h0, vecs[v].m_a});
            exp_q.push_back('{vecs[v].ea0, vecs[v].d0});
            spi_bits(vecs[v].d0, 16, rd);
            check("miso_data0", {16'h0, rd}, {16'h0, vecs[v].m_d0});
            exp_q.push_back('{vecs[v].ea1, vecs[v].d1});
            spi_bits(vecs[v].d1, 16, rd);
            check("miso_data1", {16'h0, rd}, {16'h0, vecs[v].m_d1});
            cs_high();
            check("frame_writes_drained", exp_q.size(), 0);
            check("idle_miso",   {31'h0, spi_miso}, 32'h0);
            check("idle_active", {31'h0, active},   32'h0);
        end

        // cs and the final spi_clk rise change together: word must still commit
        base = wr_cnt;
        cs_low();
        spi_bits(16'h0300, 16, rd);
        exp_q.push_back('{16'h0300, 16'h00FF});
        spi_bits(16'h00FF, 15, rd);
        spi_mosi = 1'b1;
        clks(4);
        spi_clk = 1'b1;
        spi_cs  = 1'b1;
        clks(8);
        spi_clk = 1'b0;
        clks(16);
        check("same_cycle_drained", exp_q.size(), 0);
        check("same_cycle_count", wr_cnt, base + 1);
        check("same_cycle_active", {31'h0, active}, 32'h0);

        // Partial data word then cs high: discarded, and next frame starts clean
        base = wr_cnt;
        cs_low();
        spi_bits(16'h0010, 16, rd);
        spi_bits(16'hFF80, 9, rd);
        cs_high();
        check("abort_no_write", wr_cnt, base);
        check("abort_active", {31'h0, active}, 32'h0);
        check("abort_miso", {31'h0, spi_miso}, 32'h0);
        cs_low();
        spi_bits(16'h0200, 16, rd);
        exp_q.push_back('{16'h0200, 16'h1111});
        spi_bits(16'h1111, 16, rd);
        cs_high();
        check("after_abort_drained", exp_q.size(), 0);

        // Reset in the middle of a data word with cs held low
        cs_low();
        spi_bits(16'h0400, 16, rd);
        exp_q.push_back('{16'h0400, 16'hAAAA});
        spi_bits(16'hAAAA, 16, rd);
        check("pre_reset_drained", exp_q.size(), 0);
        spi_bits(16'h5555, 8, rd);
        reset_n = 1'b0;
        clks(3);
        check("midrst_wr_en",   {31'h0, wr_en},    32'h0);
        check("midrst_wr_addr", {16'h0, wr_addr},  32'h0);
        check("midrst_wr_data", {16'h0, wr_data},  32'h0);
        check("midrst_active",  {31'h0, active},   32'h0);
        check("midrst_miso",    {31'h0, spi_miso}, 32'h0);
        reset_n = 1'b1;
        base = wr_cnt;
        clks(4);
        spi_bits(16'h5555, 16, rd);
        spi_bits(16'h3333, 16, rd);
        check("post_reset_no_write", wr_cnt, base);
        check("post_reset_active", {31'h0, active}, 32'h0);
        cs_high();
        cs_low();
        spi_bits(16'h0500, 16, rd);
        check("post_reset_miso_id", {16'h0, rd}, 32'h0000A55A);
        exp_q.push_back('{16'h0500, 16'h1357});
        spi_bits(16'h1357, 16, rd);
        cs_high();
        check("post_reset_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
